// File: rtl/core_types_pkg.sv
// Shared core types for the dispatch unit.
// Holds the default physical register file sizing, the phys reg tag type and
// the sticky error code layout reported by the ready table.
package core_types_pkg;

  localparam int NUM_PHYS_REGS = 64;
  localparam int NUM_ARCH_REGS = 32;
  localparam int LOG_PHYS_REGS = $clog2(NUM_PHYS_REGS);

  typedef logic [LOG_PHYS_REGS-1:0] phys_reg_tag_t;

  // Bit order matches error_code[2:0].
  typedef struct packed {
    logic tag_out_of_range;
    logic write_phys_reg_0;
    logic multi_writer;
  } prrt_error_code_t;

endpackage

// File: rtl/prrt_write_conflict_check.sv
// Write conflict checker for the phys reg ready table.
// Looks at every writer (dispatch dest clears and complete bus sets) in one
// cycle and flags:
//   multi_writer     - any two valid writers carry the same tag
//   write_phys_reg_0 - any valid writer targets phys reg 0
// Ports:
//   valid [NUM_WRITERS]          writer enable
//   tag   [NUM_WRITERS][TAG_W]   writer tag
module prrt_write_conflict_check #(
  parameter int NUM_WRITERS = 6,
  parameter int TAG_W       = 6
) (
  input  logic [NUM_WRITERS-1:0]            valid,
  input  logic [NUM_WRITERS-1:0][TAG_W-1:0] tag,
  output logic                              multi_writer,
  output logic                              write_phys_reg_0
);

  logic [NUM_WRITERS-1:0][NUM_WRITERS-1:0] pair_hit;
  logic [NUM_WRITERS-1:0]                  zero_hit;

  for (genvar i = 0; i < NUM_WRITERS; i++) begin : g_row
    assign zero_hit[i] = valid[i] && (tag[i] == '0);
    // Upper triangle only: each unordered pair compared once.
    for (genvar j = 0; j < NUM_WRITERS; j++) begin : g_col
      if (j > i) begin : g_cmp
        assign pair_hit[i][j] = valid[i] && valid[j] && (tag[i] == tag[j]);
      end else begin : g_none
        assign pair_hit[i][j] = 1'b0;
      end
    end
  end

  assign multi_writer     = |pair_hit;
  assign write_phys_reg_0 = |zero_hit;

endmodule

// File: rtl/phys_reg_ready_table_multi.sv
// Multi-dispatch physical register ready table.
// One ready bit per phys reg. Dispatch ways clear their dest bits, complete
// buses set theirs (set wins over clear). Each way reads two sources with
// intra-group dependence (older way's dest -> not ready) taking priority over
// same-cycle complete forwarding. Phys reg 0 is hardwired ready.
// Ports:
//   CLK, nRST                         clock, async active-low reset
//   dispatch_source_{0,1}_phys_reg_tag / _ready   per-way source lookup
//   dispatch_dest_write / _phys_reg_tag            per-way dest clear
//   complete_bus_valid / _dest_phys_reg_tag        per-bus dest set
//   ready_count                       registered popcount of the table
//   error_code                        sticky {tag_out_of_range, write_phys_reg_0, multi_writer}
//   DUT_error                         registered OR of error_code
module phys_reg_ready_table_multi
  import core_types_pkg::prrt_error_code_t;
#(
  parameter  int NUM_PHYS_REGS      = core_types_pkg::NUM_PHYS_REGS,
  parameter  int NUM_ARCH_REGS      = core_types_pkg::NUM_ARCH_REGS,
  parameter  int DISPATCH_WIDTH     = 2,
  parameter  int NUM_COMPLETE_BUSES = 4,
  parameter  bit REG_READ           = 1'b0,
  localparam int LOG_PHYS_REGS      = $clog2(NUM_PHYS_REGS),
  localparam int CNT_W              = $clog2(NUM_PHYS_REGS + 1)
) (
  input  logic                                              CLK,
  input  logic                                              nRST,
  input  logic [DISPATCH_WIDTH-1:0][LOG_PHYS_REGS-1:0]      dispatch_source_0_phys_reg_tag,
  output logic [DISPATCH_WIDTH-1:0]                         dispatch_source_0_ready,
  input  logic [DISPATCH_WIDTH-1:0][LOG_PHYS_REGS-1:0]      dispatch_source_1_phys_reg_tag,
  output logic [DISPATCH_WIDTH-1:0]                         dispatch_source_1_ready,
  input  logic [DISPATCH_WIDTH-1:0]                         dispatch_dest_write,
  input  logic [DISPATCH_WIDTH-1:0][LOG_PHYS_REGS-1:0]      dispatch_dest_phys_reg_tag,
  input  logic [NUM_COMPLETE_BUSES-1:0]                     complete_bus_valid,
  input  logic [NUM_COMPLETE_BUSES-1:0][LOG_PHYS_REGS-1:0]  complete_bus_dest_phys_reg_tag,
  output logic [CNT_W-1:0]                                  ready_count,
  output logic [2:0]                                        error_code,
  output logic                                              DUT_error
);

  localparam int NW = DISPATCH_WIDTH + NUM_COMPLETE_BUSES;
  // One extra bit so the range compare is not constant for power-of-2 sizes.
  localparam logic [LOG_PHYS_REGS:0]   NPR     = (LOG_PHYS_REGS+1)'(NUM_PHYS_REGS);
  localparam logic [NUM_PHYS_REGS-1:0] RST_TBL = NUM_PHYS_REGS'({NUM_ARCH_REGS{1'b1}});

  function automatic logic in_range(input logic [LOG_PHYS_REGS-1:0] t);
    return {1'b0, t} < NPR;
  endfunction

  logic [NUM_PHYS_REGS-1:0] tbl, tbl_nxt;
  logic [CNT_W-1:0]         cnt_nxt;
  logic [DISPATCH_WIDTH-1:0] rd0, rd1;
  prrt_error_code_t         err_q, err_now, err_nxt;
  logic                     mw, wr0, oor;

  // Next table: hold, apply clears, then sets so a set wins on a shared tag.
  always_comb begin
    tbl_nxt = tbl;
    for (int i = 0; i < DISPATCH_WIDTH; i++)
      if (dispatch_dest_write[i] && dispatch_dest_phys_reg_tag[i] != '0 &&
          in_range(dispatch_dest_phys_reg_tag[i]))
        tbl_nxt[dispatch_dest_phys_reg_tag[i]] = 1'b0;
    for (int b = 0; b < NUM_COMPLETE_BUSES; b++)
      if (complete_bus_valid[b] && complete_bus_dest_phys_reg_tag[b] != '0 &&
          in_range(complete_bus_dest_phys_reg_tag[b]))
        tbl_nxt[complete_bus_dest_phys_reg_tag[b]] = 1'b1;
    tbl_nxt[0] = 1'b1;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int k = 0; k < NUM_PHYS_REGS; k++)
      cnt_nxt = cnt_nxt + CNT_W'(tbl_nxt[k]);
  end

  // Lowest-to-highest priority: table, complete forward, older-way dest,
  // out-of-range, tag 0.
  function automatic logic src_ready(input int way, input logic [LOG_PHYS_REGS-1:0] t);
    logic r;
    r = in_range(t) ? tbl[t] : 1'b0;
    for (int b = 0; b < NUM_COMPLETE_BUSES; b++)
      if (complete_bus_valid[b] && complete_bus_dest_phys_reg_tag[b] == t) r = 1'b1;
    for (int j = 0; j < DISPATCH_WIDTH; j++)
      if (j < way && dispatch_dest_write[j] && dispatch_dest_phys_reg_tag[j] == t) r = 1'b0;
    if (!in_range(t)) r = 1'b0;
    if (t == '0)      r = 1'b1;
    return r;
  endfunction

  always_comb begin
    rd0 = '0;
    rd1 = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      rd0[i] = src_ready(i, dispatch_source_0_phys_reg_tag[i]);
      rd1[i] = src_ready(i, dispatch_source_1_phys_reg_tag[i]);
    end
  end

  if (REG_READ) begin : g_reg_read
    logic [DISPATCH_WIDTH-1:0] rd0_q, rd1_q;
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        rd0_q <= '0;
        rd1_q <= '0;
      end else begin
        rd0_q <= rd0;
        rd1_q <= rd1;
      end
    end
    assign dispatch_source_0_ready = rd0_q;
    assign dispatch_source_1_ready = rd1_q;
  end else begin : g_comb_read
    assign dispatch_source_0_ready = rd0;
    assign dispatch_source_1_ready = rd1;
  end

  // Writers ordered dispatch ways first, then complete buses.
  prrt_write_conflict_check #(
    .NUM_WRITERS (NW),
    .TAG_W       (LOG_PHYS_REGS)
  ) u_conflict (
    .valid            ({complete_bus_valid, dispatch_dest_write}),
    .tag              ({complete_bus_dest_phys_reg_tag, dispatch_dest_phys_reg_tag}),
    .multi_writer     (mw),
    .write_phys_reg_0 (wr0)
  );

  always_comb begin
    oor = 1'b0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      if (dispatch_dest_write[i] && !in_range(dispatch_dest_phys_reg_tag[i])) oor = 1'b1;
      if (!in_range(dispatch_source_0_phys_reg_tag[i]))                       oor = 1'b1;
      if (!in_range(dispatch_source_1_phys_reg_tag[i]))                       oor = 1'b1;
    end
    for (int b = 0; b < NUM_COMPLETE_BUSES; b++)
      if (complete_bus_valid[b] && !in_range(complete_bus_dest_phys_reg_tag[b])) oor = 1'b1;
  end

  assign err_now = '{tag_out_of_range: oor, write_phys_reg_0: wr0, multi_writer: mw};
  assign err_nxt = err_q | err_now;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      tbl         <= RST_TBL;
      ready_count <= CNT_W'(NUM_ARCH_REGS);
      err_q       <= '0;
      DUT_error   <= 1'b0;
    end else begin
      tbl         <= tbl_nxt;
      ready_count <= cnt_nxt;
      err_q       <= err_nxt;
      DUT_error   <= |err_nxt;
    end
  end

  assign error_code = err_q;

endmodule

// File: tb/tb_phys_reg_ready_table_multi.sv
module tb_phys_reg_ready_table_multi;

  localparam int DW = 2, NCB = 4, L = 6;

  logic                  CLK = 1'b0, nRST = 1'b0;
  logic [DW-1:0][L-1:0]  s0_tag, s1_tag, d_tag;
  logic [DW-1:0]         d_wr, s0_rdy, s1_rdy, r_s0_rdy, r_s1_rdy;
  logic [NCB-1:0]        cb_v;
  logic [NCB-1:0][L-1:0] cb_tag;
  logic [6:0]            cnt, r_cnt;
  logic [2:0]            err, r_err;
  logic                  dut_err, r_dut_err;

  int n_chk = 0, n_pass = 0;
  bit m_tbl [64];
  int m_cnt;

  always #5 CLK = ~CLK;

  phys_reg_ready_table_multi #(.REG_READ(1'b0)) u_dut (
    .CLK(CLK), .nRST(nRST),
    .dispatch_source_0_phys_reg_tag(s0_tag), .dispatch_source_0_ready(s0_rdy),
    .dispatch_source_1_phys_reg_tag(s1_tag), .dispatch_source_1_ready(s1_rdy),
    .dispatch_dest_write(d_wr), .dispatch_dest_phys_reg_tag(d_tag),
    .complete_bus_valid(cb_v), .complete_bus_dest_phys_reg_tag(cb_tag),
    .ready_count(cnt), .error_code(err), .DUT_error(dut_err)
  );

  phys_reg_ready_table_multi #(.REG_READ(1'b1)) u_dut_r (
    .CLK(CLK), .nRST(nRST),
    .dispatch_source_0_phys_reg_tag(s0_tag), .dispatch_source_0_ready(r_s0_rdy),
    .dispatch_source_1_phys_reg_tag(s1_tag), .dispatch_source_1_ready(r_s1_rdy),
    .dispatch_dest_write(d_wr), .dispatch_dest_phys_reg_tag(d_tag),
    .complete_bus_valid(cb_v), .complete_bus_dest_phys_reg_tag(cb_tag),
    .ready_count(r_cnt), .error_code(r_err), .DUT_error(r_dut_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    s0_tag = '0; s1_tag = '0; d_tag = '0; d_wr = '0; cb_v = '0; cb_tag = '0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    idle_inputs();
    @(posedge CLK); #3;
    nRST = 1'b1;
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 64; i++) m_tbl[i] = (i < 32);
    m_cnt = 32;
  endtask

  function automatic bit exp_rd(input int way, input int t);
    bit r;
    if (t == 0) return 1'b1;
    for (int j = 0; j < way; j++)
      if (d_wr[j] && int'(d_tag[j]) == t) return 1'b0;
    r = m_tbl[t];
    for (int b = 0; b < NCB; b++)
      if (cb_v[b] && int'(cb_tag[b]) == t) r = 1'b1;
    return r;
  endfunction

  task automatic m_update();
    for (int i = 0; i < DW; i++) if (d_wr[i] && d_tag[i] != 0) m_tbl[d_tag[i]] = 1'b0;
    for (int b = 0; b < NCB; b++) if (cb_v[b] && cb_tag[b] != 0) m_tbl[cb_tag[b]] = 1'b1;
    m_tbl[0] = 1'b1;
    m_cnt = 0;
    for (int i = 0; i < 64; i++) m_cnt += int'(m_tbl[i]);
  endtask

  initial begin
    logic [DW-1:0] e0, e1, p0, p1;
    int used [6];
    int t, r;
    bit dup;

    // T1: reset defaults
    do_reset();
    s0_tag[0] = 0; s1_tag[0] = 31; s0_tag[1] = 32; s1_tag[1] = 63;
    @(negedge CLK);
    chk("t1_cnt", cnt, 32);
    chk("t1_s0_rdy", s0_rdy, 2'b01);
    chk("t1_s1_rdy", s1_rdy, 2'b01);
    chk("t1_err", err, 0);
    chk("t1_dut_err", dut_err, 0);
    chk("t1_r_rdy", {r_s0_rdy, r_s1_rdy}, 0);
    chk("t1_r_cnt", r_cnt, 32);

    // T2: intra-group dependence; younger/own dests ignored
    step();
    d_wr = 2'b11; d_tag[0] = 20; d_tag[1] = 21;
    s0_tag[0] = 20; s0_tag[1] = 20; s1_tag[0] = 21; s1_tag[1] = 21;
    @(negedge CLK);
    chk("t2_s0_rdy", s0_rdy, 2'b01);
    chk("t2_s1_rdy", s1_rdy, 2'b11);
    chk("t2_r_prev", {r_s0_rdy, r_s1_rdy}, 4'b0101);
    step();
    d_wr = '0;
    chk("t2_cnt", cnt, 30);
    @(negedge CLK);
    chk("t2_after", {s0_rdy, s1_rdy}, 4'b0000);
    chk("t2_r_lat", {r_s0_rdy, r_s1_rdy}, 4'b0111);

    // T3: same-cycle complete forwarding
    step();
    cb_v = 4'b0100; cb_tag[2] = 45;
    s0_tag[0] = 44; s0_tag[1] = 44; s1_tag[0] = 45; s1_tag[1] = 45;
    @(negedge CLK);
    chk("t3_fwd", {s0_rdy, s1_rdy}, 4'b0011);
    chk("t3_r_before", r_s1_rdy, 2'b00);
    step();
    cb_v = '0;
    chk("t3_cnt", cnt, 31);
    @(negedge CLK);
    chk("t3_tbl", s1_rdy, 2'b11);
    chk("t3_r_after", r_s1_rdy, 2'b11);

    // T4: dispatch/complete conflict on 50; set wins
    step();
    d_wr = 2'b10; d_tag[1] = 50; cb_v = 4'b0001; cb_tag[0] = 50;
    s0_tag[0] = 50; s0_tag[1] = 50;
    @(negedge CLK);
    chk("t4_fwd", s0_rdy, 2'b11);
    chk("t4_err_pre", err, 0);
    step();
    // dependence beats forward on 51
    d_wr = 2'b01; d_tag[0] = 51; cb_v = 4'b0010; cb_tag[1] = 51;
    s0_tag[0] = 51; s0_tag[1] = 51;
    chk("t4_err", err, 3'b001);
    chk("t4_cnt", cnt, 32);
    @(negedge CLK);
    chk("t4_dep_beats_fwd", s0_rdy, 2'b01);
    step();
    idle_inputs();
    chk("t4_cnt2", cnt, 33);
    step(); step();
    chk("t4_sticky", err, 3'b001);
    chk("t4_dut_err", dut_err, 1);

    // T5: phys reg 0 write
    d_wr = 2'b01; d_tag[0] = 0; s0_tag[0] = 0; s0_tag[1] = 0;
    @(negedge CLK);
    chk("t5_rd0", s0_rdy, 2'b11);
    step();
    idle_inputs();
    chk("t5_err", err, 3'b011);
    chk("t5_cnt", cnt, 33);

    // T6: full-width random vs scoreboard
    do_reset();
    m_reset();
    p0 = '0; p1 = '0;
    for (int c = 0; c < 200; c++) begin
      for (int k = 0; k < 6; k++) begin
        do begin
          used[k] = $urandom_range(1, 63);
          dup = 1'b0;
          for (int m = 0; m < k; m++) if (used[m] == used[k]) dup = 1'b1;
        end while (dup);
      end
      d_wr = 2'b11; d_tag[0] = L'(used[0]); d_tag[1] = L'(used[1]);
      cb_v = 4'b1111;
      for (int b = 0; b < NCB; b++) cb_tag[b] = L'(used[2+b]);
      for (int i = 0; i < DW; i++) begin
        for (int s = 0; s < 2; s++) begin
          r = $urandom_range(0, 7);
          if (r < 3)       t = used[$urandom_range(0, 5)];
          else if (r == 3) t = 0;
          else             t = $urandom_range(0, 63);
          if (s == 0) s0_tag[i] = L'(t); else s1_tag[i] = L'(t);
        end
        e0[i] = exp_rd(i, int'(s0_tag[i]));
        e1[i] = exp_rd(i, int'(s1_tag[i]));
      end
      @(negedge CLK);
      chk("t6_s0", s0_rdy, e0);
      chk("t6_s1", s1_rdy, e1);
      chk("t6_r", {r_s0_rdy, r_s1_rdy}, {p0, p1});
      @(posedge CLK);
      m_update();
      #1;
      chk("t6_cnt", cnt, m_cnt);
      p0 = e0; p1 = e1;
    end
    chk("t6_err", err, 0);
    chk("t6_r_cnt", r_cnt, m_cnt);

    // Mid-cycle reset discards pending writes and restores defaults at once
    d_wr = 2'b11; d_tag[0] = 5; d_tag[1] = 6;
    #3;
    nRST = 1'b0;
    idle_inputs();
    s0_tag[0] = 31; s0_tag[1] = 32; s1_tag[0] = 0; s1_tag[1] = 5;
    #1;
    chk("rst_cnt", cnt, 32);
    chk("rst_err", {err, dut_err}, 0);
    chk("rst_rd", {s0_rdy, s1_rdy}, 4'b0111);
    chk("rst_r_rd", {r_s0_rdy, r_s1_rdy}, 0);
    chk("rst_r_cnt", r_cnt, 32);
    #3;
    nRST = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
